// File: rtl/tile_grid_pkg.sv
// Shared encodings for the tile grid engine: move directions, FSM states and LFSR constants.
package tile_grid_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_SPAWN,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bits 16,14,13,11 in one-based tap notation.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/line_merge.sv
// Combinational slide-and-merge of one line toward index 0; each tile merges at most once.
module line_merge #(
  parameter int N  = 4,
  parameter int VW = 4
) (
  input  logic [VW-1:0] line_in  [N],
  output logic [VW-1:0] line_out [N],
  output logic [31:0]   score_add,
  output logic          changed
);
  localparam int LW = $clog2(N);

  always_comb begin
    logic [LW-1:0] wr;
    logic [VW-1:0] pend;
    logic [VW-1:0] res;
    logic          has;
    for (int k = 0; k < N; k++) line_out[k] = '0;
    score_add = '0;
    wr        = '0;
    pend      = '0;
    res       = '0;
    has       = 1'b0;
    // A pending tile either pairs with the next equal tile or is emitted as-is.
    for (int k = 0; k < N; k++) begin
      if (line_in[k] != '0) begin
        if (has && pend == line_in[k]) begin
          res          = (pend == '1) ? pend : pend + 1'b1;
          line_out[wr] = res;
          score_add    = score_add + (32'd1 << res);
          wr           = wr + 1'b1;
          has          = 1'b0;
        end else begin
          if (has) begin
            line_out[wr] = pend;
            wr           = wr + 1'b1;
          end
          pend = line_in[k];
          has  = 1'b1;
        end
      end
    end
    if (has) line_out[wr] = pend;
  end

  always_comb begin
    changed = 1'b0;
    for (int k = 0; k < N; k++)
      if (line_out[k] != line_in[k]) changed = 1'b1;
  end

endmodule

// File: rtl/tile_grid_engine.sv
// 2048-style board engine: line-at-a-time moves, LFSR tile spawning and end-of-move status.
module tile_grid_engine
  import tile_grid_pkg::*;
#(
  parameter int N       = 4,
  parameter int VW      = 4,
  parameter int WIN_EXP = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 new_game,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_dir,
  output logic                 cmd_ready,
  input  logic [$clog2(N)-1:0] rd_row,
  input  logic [$clog2(N)-1:0] rd_col,
  output logic [VW-1:0]        rd_val,
  output logic                 busy,
  output logic                 done,
  output logic                 moved,
  output logic [31:0]          score_delta,
  output logic                 won,
  output logic                 game_over
);
  localparam int LW    = $clog2(N);
  localparam int IW    = 2 * LW;
  localparam int CELLS = N * N;

  state_t          state_reg;
  dir_t            dir_reg;
  logic [LW-1:0]   line_idx_reg;
  logic [VW-1:0]   line_reg  [N];
  logic [VW-1:0]   board_reg [CELLS];
  logic            line_changed_reg, changed_reg;
  logic [31:0]     score_acc_reg, score_delta_reg;
  logic [15:0]     lfsr_reg;
  logic [IW-1:0]   scan_reg, scan_steps_reg;
  logic [1:0]      spawn_cnt_reg;
  logic            done_reg, moved_reg, won_reg, game_over_reg;

  logic [VW-1:0]   merged [N];
  logic [31:0]     merge_score;
  logic            merge_changed;
  logic [CELLS-1:0] empty_vec, win_vec, hpair_vec, vpair_vec;

  line_merge #(.N(N), .VW(VW)) u_merge (
    .line_in   (line_reg),
    .line_out  (merged),
    .score_add (merge_score),
    .changed   (merge_changed)
  );

  // Position j of line i, counted from the edge tiles slide toward; ~j == N-1-j.
  function automatic logic [IW-1:0] cell_idx(input dir_t d, input logic [LW-1:0] i,
                                             input logic [LW-1:0] j);
    case (d)
      DIR_LEFT:  return {i, j};
      DIR_RIGHT: return {i, ~j};
      DIR_UP:    return {j, i};
      default:   return {~j, i};
    endcase
  endfunction

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    assign empty_vec[gi] = (board_reg[gi] == '0);
    assign win_vec[gi]   = (int'(board_reg[gi]) >= WIN_EXP);
    if ((gi % N) != (N - 1)) begin : g_h
      assign hpair_vec[gi] = (board_reg[gi] == board_reg[gi+1]);
    end else begin : g_hn
      assign hpair_vec[gi] = 1'b0;
    end
    if (gi < CELLS - N) begin : g_v
      assign vpair_vec[gi] = (board_reg[gi] == board_reg[gi+N]);
    end else begin : g_vn
      assign vpair_vec[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      dir_reg          <= DIR_UP;
      line_idx_reg     <= '0;
      line_changed_reg <= 1'b0;
      changed_reg      <= 1'b0;
      score_acc_reg    <= '0;
      score_delta_reg  <= '0;
      lfsr_reg         <= LFSR_SEED;
      scan_reg         <= '0;
      scan_steps_reg   <= '0;
      spawn_cnt_reg    <= '0;
      done_reg         <= 1'b0;
      moved_reg        <= 1'b0;
      won_reg          <= 1'b0;
      game_over_reg    <= 1'b0;
      for (int k = 0; k < CELLS; k++) board_reg[k] <= '0;
      for (int k = 0; k < N; k++) line_reg[k] <= '0;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_feedback(lfsr_reg)};
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (new_game) begin
            for (int k = 0; k < CELLS; k++) board_reg[k] <= '0;
            spawn_cnt_reg  <= 2'd2;
            scan_reg       <= lfsr_reg[IW-1:0];
            scan_steps_reg <= '0;
            changed_reg    <= 1'b0;
            score_acc_reg  <= '0;
            state_reg      <= ST_SPAWN;
          end else if (cmd_valid) begin
            dir_reg       <= dir_t'(cmd_dir);
            line_idx_reg  <= '0;
            changed_reg   <= 1'b0;
            score_acc_reg <= '0;
            state_reg     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          for (int j = 0; j < N; j++)
            line_reg[j] <= board_reg[cell_idx(dir_reg, line_idx_reg, LW'(j))];
          state_reg <= ST_MERGE;
        end
        ST_MERGE: begin
          for (int j = 0; j < N; j++) line_reg[j] <= merged[j];
          line_changed_reg <= merge_changed;
          score_acc_reg    <= score_acc_reg + merge_score;
          state_reg        <= ST_WRITE;
        end
        ST_WRITE: begin
          for (int j = 0; j < N; j++)
            board_reg[cell_idx(dir_reg, line_idx_reg, LW'(j))] <= line_reg[j];
          changed_reg <= changed_reg | line_changed_reg;
          if (line_idx_reg == LW'(N - 1)) begin
            if (changed_reg | line_changed_reg) begin
              spawn_cnt_reg  <= 2'd1;
              scan_reg       <= lfsr_reg[IW-1:0];
              scan_steps_reg <= '0;
              state_reg      <= ST_SPAWN;
            end else begin
              state_reg <= ST_CHECK;
            end
          end else begin
            line_idx_reg <= line_idx_reg + 1'b1;
            state_reg    <= ST_LOAD;
          end
        end
        ST_SPAWN: begin
          scan_reg <= scan_reg + 1'b1;
          if (board_reg[scan_reg] == '0) begin
            board_reg[scan_reg] <= (lfsr_reg[15:12] == 4'd0) ? VW'(2) : VW'(1);
            spawn_cnt_reg       <= spawn_cnt_reg - 1'b1;
            scan_steps_reg      <= '0;
            if (spawn_cnt_reg == 2'd1) state_reg <= ST_CHECK;
          end else begin
            scan_steps_reg <= scan_steps_reg + 1'b1;
            if (scan_steps_reg == '1) state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          won_reg         <= |win_vec;
          game_over_reg   <= ~(|empty_vec) & ~(|hpair_vec) & ~(|vpair_vec);
          moved_reg       <= changed_reg;
          score_delta_reg <= score_acc_reg;
          done_reg        <= 1'b1;
          state_reg       <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign rd_val      = board_reg[{rd_row, rd_col}];
  assign done        = done_reg;
  assign moved       = moved_reg;
  assign score_delta = score_delta_reg;
  assign won         = won_reg;
  assign game_over   = game_over_reg;

endmodule

// File: doc/tile_grid_engine.md
TILE_GRID_ENGINE -- requirements
Module: tile_grid_engine

Interface
REQ-001 SHALL have parameter N, default 4, board dimension (cells per row/column); legal values 2, 4, 8.
REQ-002 SHALL have parameter VW, default 4, width of a cell exponent code (0 = empty, k = tile 2^k).
REQ-003 SHALL have parameter WIN_EXP, default 11, exponent that asserts won.
REQ-004 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port new_game  in  1  level sampled in IDLE; request to clear the board and spawn two tiles.
REQ-007 SHALL have port cmd_valid  in  1  move request.
REQ-008 SHALL have port cmd_dir  in  2  move direction: 00 up, 01 down, 10 left, 11 right.
REQ-009 SHALL have port cmd_ready  out  1  high only in IDLE.
REQ-010 SHALL have port rd_row, rd_col  in  clog2(N) each  renderer read address.
REQ-011 SHALL have port rd_val  out  VW  board[rd_row][rd_col], combinational, valid every cycle including while busy.
REQ-012 SHALL have port busy  out  1  high in every state other than IDLE.
REQ-013 SHALL have port done  out  1  one-cycle pulse when a command or new_game completes.
REQ-014 SHALL have port moved  out  1  registered; 1 if the last move changed any cell; held until the next done.
REQ-015 SHALL have port score_delta  out  32  registered sum of 2^(merged exponent) for the last move; held until the next done.
REQ-016 SHALL have ports won and game_over  out  1 each  registered board status, updated in CHECK.

Function
REQ-017 SHALL implement states IDLE, LOAD, MERGE, WRITE, SPAWN, CHECK and DONE.
REQ-018 In IDLE, a handshake (cmd_valid & cmd_ready) SHALL latch cmd_dir, clear the line index and go to LOAD.
REQ-019 In IDLE, new_game SHALL win over a simultaneous cmd_valid, clear all cells, and go to SPAWN with a spawn count of 2.
REQ-020 LOAD SHALL copy line i into a line buffer, ordered from the leading edge: left = row i, col 0..N-1; right = row i, col N-1..0; up = col i, row 0..N-1; down = col i, row N-1..0.
REQ-021 MERGE SHALL compress non-zero entries toward index 0 and merge equal adjacent pairs, starting from index 0.
REQ-022 Each tile SHALL merge at most once per move; [1,1,1,1] SHALL become [2,2,0,0].
REQ-023 A merged exponent SHALL saturate at 2^VW-1.
REQ-024 MERGE SHALL add 2^(result exponent) to a score accumulator.
REQ-025 WRITE SHALL store the buffer back in the same order, set a changed flag if any cell differs, and increment i.
REQ-026 After WRITE, the engine SHALL return to LOAD while i < N; otherwise it SHALL go to SPAWN if changed, else to CHECK.
REQ-027 A move SHALL take 3N cycles from handshake to the end of the last WRITE.
REQ-028 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock.
REQ-029 On entering SPAWN, the engine SHALL load a scan index = lfsr[2*log2(N)-1:0].
REQ-030 SPAWN SHALL test one cell per cycle, incrementing the index modulo N*N; the first empty cell SHALL receive exponent 2 if lfsr[15:12]==0, else 1.
REQ-031 SPAWN SHALL decrement the spawn count after each placement, leave when it reaches zero, and go to CHECK after N*N cycles without finding an empty cell.
REQ-032 CHECK SHALL take one cycle and set game_over = no empty cell and no horizontally or vertically adjacent equal pair.
REQ-033 CHECK SHALL set won = any cell >= WIN_EXP.
REQ-034 DONE SHALL pulse done for one cycle, update moved and score_delta, and return to IDLE.
REQ-035 A move with game_over=1 SHALL still run: moved=0, score_delta=0, no spawn.
REQ-036 cmd_valid and new_game outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-037 rst_n low SHALL asynchronously force: state IDLE, all cells 0, lfsr 16'hACE1, moved 0, score_delta 0, won 0, game_over 0, done 0, busy 0.
REQ-038 rst_n low SHALL also force cmd_ready 1 once released; asserting it mid-operation SHALL abandon the move with no partial writes afterwards.

Structure
REQ-039 Package tile_grid_pkg SHALL hold the direction encoding, the state enum, the LFSR seed and the LFSR taps.
REQ-040 Single-line compress/merge SHALL be a combinational sub-module line_merge (N, VW) with outputs line_out, score_add and changed.

Verification
REQ-041 Row0=[1,1,2,2], other cells 0, left -> row0=[2,3,0,0] plus one spawned tile, score_delta=12, moved=1, done 12 cycles after handshake plus spawn and CHECK cycles.
REQ-042 Row0=[1,1,1,1], left -> [2,2,0,0], score_delta=8; row0=[1,0,0,1], right -> [0,0,0,2], score_delta=4.
REQ-043 Full board of 1..4 in Latin-square order, any direction -> moved=0, no spawn, board unchanged, game_over=1.
REQ-044 VW=4, two adjacent 15s, merge -> 15 (saturated), score_delta=32768.
REQ-045 new_game in IDLE -> exactly two non-zero cells, each value 1 or 2; cmd_valid asserted while busy -> ignored, cmd_ready=0.
REQ-046 rst_n low during MERGE -> all cells 0 and IDLE immediately; rst_n high -> cmd_ready=1 next cycle.
